// File: rtl/multichannel_delay.sv
// N-channel signed fixed-point delay with programmable delay and gain.
// One multiplier and one delay RAM are shared across channels by a sequencer.
module multichannel_delay #(
    parameter int    DATA_WIDTH   = 24,
    parameter int    NUM_CHANNELS = 2,
    parameter int    MAX_DELAY    = 4096,
    parameter int    GAIN_WIDTH   = 16,
    parameter string FEED_TYPE    = "FEEDBACK"
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic                               i_data_valid,
    output logic                               o_ready,
    input  logic [$clog2(MAX_DELAY)-1:0]       i_delay_samples,
    input  logic [GAIN_WIDTH-1:0]              i_gain,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data,
    output logic                               o_data_valid,
    output logic                               o_overrun
);

    localparam int DW    = DATA_WIDTH;
    localparam int GW    = GAIN_WIDTH;
    localparam int PW    = DW + GW;
    localparam int FW    = DW * NUM_CHANNELS;
    localparam int AW    = $clog2(MAX_DELAY);
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DEPTH = MAX_DELAY << CW;
    localparam bit IS_FB = (FEED_TYPE == "FEEDBACK");
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CHANNELS - 1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(MAX_DELAY);

    if (FEED_TYPE != "FEEDFORWARD" && FEED_TYPE != "FEEDBACK") begin : g_bad_feed_type
        $error("multichannel_delay: FEED_TYPE must be FEEDFORWARD or FEEDBACK");
    end

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_MAC, S_WR, S_DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         ch_q;
    logic [FW-1:0]         frame_q;
    logic [GW-1:0]         gain_q;
    logic [AW-1:0]         dly_q;
    logic [AW-1:0]         wptr_q;
    logic [AW:0]           fill_q;
    logic [DW-1:0]         rdata_q;
    logic [PW-1:0]         prod_q;
    logic [FW-1:0]         slot_q;
    logic [FW-1:0]         o_data_q;
    logic                  valid_q;
    logic                  ready_q;
    logic                  overrun_q;
    logic [DW-1:0]         mem_q [DEPTH];

    logic [AW+CW-1:0]      raddr_d;
    logic [AW+CW-1:0]      waddr_d;
    logic [DW-1:0]         x_d;
    logic [DW-1:0]         d_d;
    logic [PW-1:0]         mult_d;
    logic [DW:0]           y_d;
    logic [DW-1:0]         ysat_d;
    logic [DW-1:0]         wdata_d;
    logic                  unused_prod_lsbs;

    // Datapath: addressing, fill guard, multiply, rounding shift and saturation
    always_comb begin
        raddr_d = {wptr_q - dly_q, ch_q};
        waddr_d = {wptr_q, ch_q};
        x_d     = frame_q[ch_q*DW +: DW];
        // Samples older than what has been written since reset read as silence
        if ({1'b0, dly_q} > fill_q) begin
            d_d = '0;
        end else begin
            d_d = rdata_q;
        end
        mult_d = $signed({{GW{d_d[DW-1]}}, d_d}) * $signed({{DW{gain_q[GW-1]}}, gain_q});
        // Dropping the low GW-1 product bits is an arithmetic shift (floor)
        y_d = {x_d[DW-1], x_d} + prod_q[PW-1:GW-1];
        if (y_d[DW] != y_d[DW-1]) begin
            ysat_d = y_d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            ysat_d = y_d[DW-1:0];
        end
        if (IS_FB) begin
            wdata_d = ysat_d;
        end else begin
            wdata_d = x_d;
        end
        unused_prod_lsbs = ^prod_q[GW-2:0];
    end

    // Delay RAM: synchronous read in RD, write in WR; contents never reset
    always_ff @(posedge i_clock) begin
        if (state_q == S_WR) begin
            mem_q[waddr_d] <= wdata_d;
        end
        if (state_q == S_RD) begin
            rdata_q <= mem_q[raddr_d];
        end
    end

    // Channel sequencer with frame latch, pointer/fill bookkeeping and outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            frame_q   <= '0;
            gain_q    <= '0;
            dly_q     <= AW'(1);
            wptr_q    <= '0;
            fill_q    <= '0;
            prod_q    <= '0;
            slot_q    <= '0;
            o_data_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (i_data_valid && !ready_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_data_valid) begin
                        frame_q <= i_data;
                        gain_q  <= i_gain;
                        dly_q   <= (i_delay_samples == '0) ? AW'(1) : i_delay_samples;
                        ch_q    <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_RD;
                    end
                end
                S_RD:  state_q <= S_WT;
                S_WT:  state_q <= S_MAC;
                S_MAC: begin
                    prod_q  <= mult_d;
                    state_q <= S_WR;
                end
                S_WR: begin
                    slot_q[ch_q*DW +: DW] <= ysat_d;
                    if (ch_q == LAST_CH) begin
                        state_q <= S_DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= S_RD;
                    end
                end
                S_DONE: begin
                    o_data_q <= slot_q;
                    valid_q  <= 1'b1;
                    wptr_q   <= wptr_q + 1'b1;
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + 1'b1;
                    end
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data       = o_data_q;
    assign o_data_valid = valid_q;
    assign o_ready      = ready_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_multichannel_delay.sv
// Scoreboard bench: both feed modes run side by side on shared stimulus,
// checked against a frame-indexed reference model of the delay line.
module tb_multichannel_delay;

    localparam int DW   = 24;
    localparam int NCH  = 2;
    localparam int MAXD = 16;
    localparam int GW   = 16;
    localparam int AW   = 4;
    localparam int FW   = DW * NCH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] data = '0;
    logic          data_valid = 1'b0;
    logic [AW-1:0] delay = '0;
    logic [GW-1:0] gain = '0;

    logic          ff_ready, ff_valid, ff_ovr;
    logic [FW-1:0] ff_data;
    logic          fb_ready, fb_valid, fb_ovr;
    logic [FW-1:0] fb_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // hist[mode][ch][n]: value stored into the delay line by frame n (mode 0 FF, 1 FB)
    int hist [2][NCH][1024];
    int nfr = 0;
    logic [FW-1:0] exp_ff_q[$];
    logic [FW-1:0] exp_fb_q[$];
    int            cyc_ff_q[$];
    int            cyc_fb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multichannel_delay #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .MAX_DELAY(MAXD),
                         .GAIN_WIDTH(GW), .FEED_TYPE("FEEDFORWARD")) u_ff (
        .i_clock(clk), .i_reset_n(rst_n), .i_data(data), .i_data_valid(data_valid),
        .o_ready(ff_ready), .i_delay_samples(delay), .i_gain(gain),
        .o_data(ff_data), .o_data_valid(ff_valid), .o_overrun(ff_ovr));

    multichannel_delay #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .MAX_DELAY(MAXD),
                         .GAIN_WIDTH(GW), .FEED_TYPE("FEEDBACK")) u_fb (
        .i_clock(clk), .i_reset_n(rst_n), .i_data(data), .i_data_valid(data_valid),
        .o_ready(fb_ready), .i_delay_samples(delay), .i_gain(gain),
        .o_data(fb_data), .o_data_valid(fb_valid), .o_overrun(fb_ovr));

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    // Reference: y = sat(x + floor(d*g/2^15)), d = value stored D frames ago or 0 if not yet written
    task automatic model_frame(input int xs[NCH], input int dly, input int g);
        int            dd, fill, gs;
        longint        d, y;
        logic [FW-1:0] e [2];
        logic [DW-1:0] t;
        dd   = (dly == 0) ? 1 : dly;
        fill = (nfr < MAXD) ? nfr : MAXD;
        gs   = (g >= 32768) ? g - 65536 : g;
        for (int m = 0; m < 2; m++) begin
            e[m] = '0;
            for (int c = 0; c < NCH; c++) begin
                d = (dd > fill) ? 0 : longint'(hist[m][c][nfr-dd]);
                y = sat(longint'(xs[c]) + ((d * longint'(gs)) >>> 15));
                hist[m][c][nfr] = (m == 1) ? int'(y) : xs[c];
                t = DW'(y);
                e[m][c*DW +: DW] = t;
            end
        end
        exp_ff_q.push_back(e[0]);
        exp_fb_q.push_back(e[1]);
        cyc_ff_q.push_back(cyc + 10);
        cyc_fb_q.push_back(cyc + 10);
        nfr++;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ff_ready === 1'b1 && fb_ready === 1'b1) return;
        end
        check("ready_timeout", ff_ready & fb_ready, 1);
    endtask

    // Accept one frame, then scramble the inputs so mid-frame changes are exercised
    task automatic send(input int x0, input int x1, input int dly, input int g);
        int xs[NCH];
        wait_ready();
        xs[0] = x0;
        xs[1] = x1;
        data       = {DW'(x1), DW'(x0)};
        delay      = AW'(dly);
        gain       = GW'(g);
        data_valid = 1'b1;
        model_frame(xs, dly, g);
        @(negedge clk);
        data_valid = 1'b0;
        data       = {$urandom, $urandom};
        delay      = AW'($urandom);
        gain       = GW'($urandom);
    endtask

    task automatic flush_model();
        exp_ff_q.delete();
        exp_fb_q.delete();
        cyc_ff_q.delete();
        cyc_fb_q.delete();
        nfr = 0;
    endtask

    task automatic do_reset();
        wait_ready();
        rst_n = 1'b0;
        data_valid = 1'b0;
        flush_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: pops one expected frame per output strobe and checks data and latency
    initial begin
        logic [FW-1:0] e;
        int            c;
        forever begin
            @(negedge clk);
            if (ff_valid === 1'b1) begin
                if (exp_ff_q.size() == 0) begin
                    check("ff_spurious_valid", ff_valid, 0);
                end else begin
                    e = exp_ff_q.pop_front();
                    c = cyc_ff_q.pop_front();
                    check("ff_latency", cyc, c);
                    check("ff_ch0", $signed(ff_data[DW-1:0]), $signed(e[DW-1:0]));
                    check("ff_ch1", $signed(ff_data[FW-1:DW]), $signed(e[FW-1:DW]));
                end
            end
            if (fb_valid === 1'b1) begin
                if (exp_fb_q.size() == 0) begin
                    check("fb_spurious_valid", fb_valid, 0);
                end else begin
                    e = exp_fb_q.pop_front();
                    c = cyc_fb_q.pop_front();
                    check("fb_latency", cyc, c);
                    check("fb_ch0", $signed(fb_data[DW-1:0]), $signed(e[DW-1:0]));
                    check("fb_ch1", $signed(fb_data[FW-1:DW]), $signed(e[FW-1:DW]));
                end
            end
        end
    end

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        check("rst_ff_data", ff_data, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_ff_valid", ff_valid, 0);
        check("rst_fb_valid", fb_valid, 0);
        check("rst_ff_ovr", ff_ovr, 0);
        check("rst_fb_ovr", fb_ovr, 0);
        check("rst_ff_ready", ff_ready, 1);
        check("rst_fb_ready", fb_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse, gain +0.5 then -0.5
        for (int i = 0; i < 12; i++) send((i == 0) ? 1000 : 0, 0, 3, 16'h4000);
        do_reset();
        for (int i = 0; i < 12; i++) send((i == 0) ? 1000 : 0, 0, 3, 16'hC000);
        do_reset();

        // Saturation at both rails
        for (int i = 0; i < 4; i++) send(8000000, -8000000, 1, 16'h7FFF);
        for (int i = 0; i < 4; i++) send(-8000000, 8000000, 1, 16'h7FFF);
        do_reset();

        // Fill guard with a ramp, then delay 0 versus 1
        for (int i = 0; i < 12; i++) send(i * 1000, -i * 1000, 10, 16'h4000);
        do_reset();
        for (int i = 0; i < 6; i++) send(i * 777 + 5, 3 - i * 313, i % 2, 16'h6000);
        do_reset();

        // Pointer wrap-around, then random traffic on top
        for (int i = 0; i < 40; i++) send(i * 100, -i * 37, 15, 16'h4000);
        for (int i = 0; i < 50; i++) begin
            send(int'($urandom_range(0, 16777215)) - 8388608,
                 int'($urandom_range(0, 16777215)) - 8388608,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
        end

        // Overrun: frame offered while busy is dropped and flags sticky
        send(1234567, -7654321, 2, 16'h2000);
        @(negedge clk);
        @(negedge clk);
        check("busy_ff_ready", ff_ready, 0);
        data       = {DW'(99), DW'(99)};
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("ovr_ff_set", ff_ovr, 1);
        check("ovr_fb_set", fb_ovr, 1);

        // Reset during MAC aborts the frame and clears everything
        send(4000000, -4000000, 1, 16'h4000);
        @(negedge clk);
        @(negedge clk);
        check("ovr_ff_sticky", ff_ovr, 1);
        rst_n = 1'b0;
        flush_model();
        #1;
        check("midrst_ff_data", ff_data, 0);
        check("midrst_fb_data", fb_data, 0);
        check("midrst_ff_valid", ff_valid, 0);
        check("midrst_ff_ovr", ff_ovr, 0);
        check("midrst_fb_ovr", fb_ovr, 0);
        check("midrst_ff_ready", ff_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send(50000 + i * 3, -20000 + i, 2, 16'h4000);

        n = 0;
        while ((exp_ff_q.size() != 0 || exp_fb_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ff_pending", exp_ff_q.size(), 0);
        check("fb_pending", exp_fb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
